alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle 8-op ALU with valid/ready handshakes and registered result/flags.
// One op in flight; mul runs an iterative shift-add over WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [2:0]       d
);

  typedef enum logic [2:0] {
    OP_SLA = 3'b000, OP_SRA = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
    OP_MUL = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_NOT = 3'b111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;   // upper half of the 2*WIDTH accumulator
  logic [WIDTH-1:0] lo_q, lo_d;   // multiplier, shifted out as product bits shift in
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [2:0]       d_q, d_d;

  // Single-cycle ops, evaluated on the raw inputs at the accept edge
  logic [WIDTH-1:0] alu_c;
  logic             alu_cy, alu_ov;
  logic [WIDTH:0]   shl, shr, sum, dif;

  always_comb begin
    shl    = {1'b0, a} << b;
    shr    = $signed({a, 1'b0}) >>> b;
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} - {1'b0, b};
    alu_c  = '0;
    alu_cy = 1'b0;
    alu_ov = 1'b0;
    case (op_e'(opcode))
      OP_SLA: begin alu_c = shl[WIDTH-1:0]; alu_cy = shl[WIDTH]; end
      // shifted-out bit lands in the guard LSB; s>WIDTH leaves the sign there
      OP_SRA: begin alu_c = shr[WIDTH:1];   alu_cy = shr[0];     end
      OP_ADD: begin
        alu_c  = sum[WIDTH-1:0];
        alu_cy = sum[WIDTH];
        alu_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_c  = dif[WIDTH-1:0];
        alu_cy = dif[WIDTH];
        alu_ov = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_c = a & b;
      OP_OR:   alu_c = a | b;
      OP_NOT:  alu_c = ~a;
      default: alu_c = '0;
    endcase
  end

  // One multiplier bit per cycle: conditional add into hi, then shift right
  logic [WIDTH:0] step;
  assign step = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    d_d     = d_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        if (op_e'(opcode) == OP_MUL) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end else begin
          c_d     = alu_c;
          d_d     = {alu_ov, alu_cy, alu_c == '0};
          state_d = S_DONE;
        end
      end
      S_MUL: begin
        hi_d  = step[WIDTH:1];
        lo_d  = {step[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          c_d     = lo_d;
          d_d     = {1'b0, hi_d != '0, lo_d == '0};
          state_d = S_DONE;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign c         = c_q;
  assign d         = d_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed results, flags, latency, backpressure, reset.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] a, b, c;
  logic [2:0]   opcode, d;
  int           checks = 0, failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .c(c), .d(d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure edges from accept to out_valid, check result,
  // optionally hold off the consumer while poking in_valid, then consume.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ec, input logic [2:0] ed,
                        input int elat, input int hold);
    int lat;
    @(negedge clk);
    a = av; b = bv; opcode = op; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(elat));
    chk({tag, ".c"}, 64'(c), 64'(ec));
    chk({tag, ".d"}, 64'(d), 64'(ed));
    chk({tag, ".busy"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = i[0]; a = 32'h1234_5678; b = 32'h1; opcode = 3'b010;
      @(posedge clk); #1;
      chk({tag, ".hold_c"}, 64'(c), 64'(ec));
      chk({tag, ".hold_rv"}, {62'd0, in_ready, out_valid}, 64'b01);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".consumed"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {in_ready, out_valid, d, c}, {1'b1, 1'b0, 3'b000, 32'h0});
    @(negedge clk); rst_n = 1'b1;

    run_op("not",     3'b111, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0,          3'b001, 0, 0);
    run_op("add_ov",  3'b010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000,  3'b100, 0, 0);
    run_op("add_cy",  3'b010, 32'hFFFF_FFFF, 32'h1,         32'h0,          3'b011, 0, 0);
    run_op("sub",     3'b011, 32'd3,         32'd5,         32'hFFFF_FFFE,  3'b010, 0, 0);
    run_op("sub_ov",  3'b011, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF,  3'b100, 0, 0);
    run_op("mul_ovf", 3'b100, 32'h0001_0000, 32'h0001_0000, 32'h0,          3'b011, W, 0);
    run_op("mul",     3'b100, 32'd1234,      32'd5678,      32'd7006652,    3'b000, W, 0);
    run_op("sra",     3'b001, 32'h8000_0000, 32'd4,         32'hF800_0000,  3'b000, 0, 0);
    run_op("sra_big", 3'b001, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF,  3'b010, 0, 0);
    run_op("sra_cy",  3'b001, 32'h0000_0003, 32'd1,         32'h0000_0001,  3'b010, 0, 0);
    run_op("sla",     3'b000, 32'h8000_0001, 32'd1,         32'h2,          3'b010, 0, 0);
    run_op("sla_w",   3'b000, 32'h0000_0001, 32'd32,        32'h0,          3'b011, 0, 0);
    run_op("sla_big", 3'b000, 32'hFFFF_FFFF, 32'd40,        32'h0,          3'b001, 0, 0);
    run_op("sla_0",   3'b000, 32'h8000_0001, 32'd0,         32'h8000_0001,  3'b000, 0, 0);
    run_op("and",     3'b101, 32'hF0F0_00FF, 32'h0FF0_000F, 32'h00F0_000F,  3'b000, 0, 0);
    run_op("or_bp",   3'b110, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F,  3'b000, 0, 10);

    // Reset mid-multiply: c still holds the previous result until then
    @(negedge clk);
    a = 32'd7; b = 32'd9; opcode = 3'b100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mul", {in_ready, out_valid, d, c}, {1'b1, 1'b0, 3'b000, 32'h0});
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_mul_no_out", 64'(seen), 64'd0);

    run_op("post_rst", 3'b010, 32'd100, 32'd23, 32'd123, 3'b000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
